// File: rtl/mips_cpu_muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer and owner of the HI/LO register pair.
// Latency: start at edge E0 -> done pulses in the cycle after E33 (fixed); with
//   MULDIV_EARLY_OUT_EN defined, multiplies finish after E(k+1), k = max(1, MSB index of |opb| + 1).
// Backpressure: busy=1 from after E0 through E33; start, mthi and mtlo are ignored while busy.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   clk_enable        global enable; 0 freezes every register
//   start, op[1:0]    launch (IDLE only); op 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   opa, opb [31:0]   rs / rt operands, sampled with start
//   mthi, mtlo        write mt_data[31:0] into HI / LO (IDLE, start=0)
//   busy              state != IDLE
//   done              one-cycle pulse after HI/LO take a new result
//   hi, lo [31:0]     HI / LO registers
// Optional feature macro: MULDIV_EARLY_OUT_EN (early termination of multiplies).

module mips_cpu_muldiv_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] mt_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state;
    logic        is_div;     // latched op[1]
    logic        neg_a;      // dividend / multiplicand was negative (signed ops)
    logic        neg_b;      // divisor / multiplier was negative (signed ops)
    logic [5:0]  counter;
    // Shared datapath:
    //   multiply: acc = partial product, mcand = shifting multiplicand, mplier = shifting multiplier
    //   divide:   acc[31:0] = partial remainder, mcand[31:0] = divisor,
    //             mplier = dividend shifting out at the top / quotient shifting in at the bottom
    logic [63:0] acc;
    logic [63:0] mcand;
    logic [31:0] mplier;

    // Operand conditioning at launch
    logic        sign_a;
    logic        sign_b;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic        div_zero;

    always_comb begin
        sign_a   = ~op[0] & opa[31];
        sign_b   = ~op[0] & opb[31];
        abs_a    = sign_a ? -opa : opa;
        abs_b    = sign_b ? -opb : opb;
        div_zero = op[1] && (opb == 32'd0);
    end

    // One restoring-division step; 33 bits because the shifted remainder can
    // exceed 32 bits when the divisor is above 2^31.
    logic [32:0] rem_sh;
    logic [32:0] rem_sub;
    logic        rem_ge;

    always_comb begin
        rem_sh  = {acc[31:0], mplier[31]};
        rem_sub = rem_sh - {1'b0, mcand[31:0]};
        rem_ge  = (rem_sh >= {1'b0, mcand[31:0]});
    end

    // One shift-add multiply step
    logic [63:0] acc_add;

    always_comb begin
        acc_add = acc + (mplier[0] ? mcand : 64'd0);
    end

    // Final iteration detection
    logic last_iter;

    always_comb begin
`ifdef MULDIV_EARLY_OUT_EN
        // A multiply is complete once no set multiplier bits remain after this step.
        last_iter = (counter == 6'd31) || (!is_div && (mplier[31:1] == 31'd0));
`else
        last_iter = (counter == 6'd31);
`endif
    end

    // Sign fix-up of the magnitude results
    logic        neg_res;
    logic [63:0] prod_out;
    logic [31:0] quot_out;
    logic [31:0] rem_out;

    always_comb begin
        neg_res  = neg_a ^ neg_b;
        prod_out = neg_res ? -acc : acc;
        quot_out = neg_res ? -mplier : mplier;
        rem_out  = neg_a ? -acc[31:0] : acc[31:0];
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            is_div  <= 1'b0;
            neg_a   <= 1'b0;
            neg_b   <= 1'b0;
            counter <= 6'd0;
            acc     <= 64'd0;
            mcand   <= 64'd0;
            mplier  <= 32'd0;
            done    <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else if (clk_enable) begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div  <= op[1];
                        // Divide by zero runs unsigned on the raw dividend: the
                        // quotient saturates to all ones and the remainder is opa.
                        neg_a   <= sign_a & ~div_zero;
                        neg_b   <= sign_b & ~div_zero;
                        counter <= 6'd0;
                        acc     <= 64'd0;
                        mcand   <= {32'd0, (op[1] ? abs_b : abs_a)};
                        mplier  <= op[1] ? (div_zero ? opa : abs_a) : abs_b;
                        state   <= CALC;
                    end else begin
                        if (mthi) hi <= mt_data;
                        if (mtlo) lo <= mt_data;
                    end
                end
                CALC: begin
                    counter <= counter + 6'd1;
                    if (is_div) begin
                        acc    <= {32'd0, (rem_ge ? rem_sub[31:0] : rem_sh[31:0])};
                        mplier <= {mplier[30:0], rem_ge};
                    end else begin
                        acc    <= acc_add;
                        mcand  <= {mcand[62:0], 1'b0};
                        mplier <= {1'b0, mplier[31:1]};
                    end
                    if (last_iter) state <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        lo <= quot_out;
                        hi <= rem_out;
                    end else begin
                        hi <= prod_out[63:32];
                        lo <= prod_out[31:0];
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
